// File: rtl/hazard_forward_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_if
//
// Bundle of the pipeline-side signals exchanged with hazard_forward_unit.
// The pipeline (master) drives decode/EX/MEM/WB information and receives
// enables, flush/bubble controls and the forwarded ALU operands.  The hazard
// unit itself connects through the slave modport.
//
// Signal summary (pipeline -> unit):
//   mem_hold                memory stage busy, freezes the whole pipeline
//   id_valid                decode slot holds a real instruction
//   id_rs, id_rd            decode source / destination register addresses
//   id_rs_used, id_rd_used  decode operand actually read
//   id_reg_write            decode instruction writes a register
//   id_mem_read             decode instruction is a load
//   ex_branch_taken         EX resolved a taken branch/jump
//   ex_rs_data, ex_rd_data  operands from the ID-EX register
//   mem_result              ALU result held in EX-MEM
//   wb_result               write-back data
// Signal summary (unit -> pipeline):
//   pc_en, fd_en            PC and IF-ID register enables
//   fd_flush                clear IF-ID to NOP
//   de_bubble               load NOP into ID-EX
//   fwd_src_sel/fwd_dst_sel 0 = register file, 1 = MEM, 2 = WB
//   src_fwd, dst_fwd        forwarded ALU operands
//   state                   0 RUN, 1 STALL, 2 FLUSH
//   stall_cnt               saturating count of stall + flush cycles
// -----------------------------------------------------------------------------
interface hazard_forward_unit_if #(
   parameter int REG_AW = 3,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
);
   logic              mem_hold;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rd;
   logic              id_rs_used;
   logic              id_rd_used;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              ex_branch_taken;
   logic [DATA_W-1:0] ex_rs_data;
   logic [DATA_W-1:0] ex_rd_data;
   logic [DATA_W-1:0] mem_result;
   logic [DATA_W-1:0] wb_result;

   logic              pc_en;
   logic              fd_en;
   logic              fd_flush;
   logic              de_bubble;
   logic [1:0]        fwd_src_sel;
   logic [1:0]        fwd_dst_sel;
   logic [DATA_W-1:0] src_fwd;
   logic [DATA_W-1:0] dst_fwd;
   logic [1:0]        state;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output mem_hold, id_valid, id_rs, id_rd, id_rs_used, id_rd_used,
             id_reg_write, id_mem_read, ex_branch_taken,
             ex_rs_data, ex_rd_data, mem_result, wb_result,
      input  pc_en, fd_en, fd_flush, de_bubble, fwd_src_sel, fwd_dst_sel,
             src_fwd, dst_fwd, state, stall_cnt
   );

   modport slave (
      input  mem_hold, id_valid, id_rs, id_rd, id_rs_used, id_rd_used,
             id_reg_write, id_mem_read, ex_branch_taken,
             ex_rs_data, ex_rd_data, mem_result, wb_result,
      output pc_en, fd_en, fd_flush, de_bubble, fwd_src_sel, fwd_dst_sel,
             src_fwd, dst_fwd, state, stall_cnt
   );
endinterface

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard detection and operand forwarding for the five-stage pipeline.  A
// private scoreboard mirrors the instructions in EX, MEM and WB; from it the
// unit selects ALU operands (register file / MEM result / WB data) and drives
// PC / IF-ID enables, IF-ID flush and ID-EX bubble.  It also sequences the
// multi-cycle flush after a taken branch, freezes everything on mem_hold and
// counts bubble cycles in a saturating counter.
//
// Parameters:
//   REG_AW       register address width
//   DATA_W       operand width
//   FLUSH_DEPTH  IF-ID flush cycles after a taken branch/jump (1..7)
//   CNT_W        stall counter width
//
// Ports:
//   clk    rising-edge clock
//   RESET  asynchronous active-low reset
//   hfu    pipeline bundle (slave side), see hazard_forward_unit_if
//
// Build option:
//   HDU_LOAD_STALL_EN  when defined, load-use hazards stall decode (STALL
//                      state).  When undefined the toolchain is trusted to
//                      pad loads with two NOPs and STALL is never entered.
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
   parameter int REG_AW      = 3,
   parameter int DATA_W      = 16,
   parameter int FLUSH_DEPTH = 2,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 RESET,
   hazard_forward_unit_if.slave hfu
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rd;
      logic              rs_used;
      logic              rd_used;
      logic              reg_write;
      logic              mem_read;
   } slot_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Counter value loaded on a taken branch; the branch cycle itself is the
   // first flush cycle, so FLUSH lasts FLUSH_DEPTH-1 further cycles.
   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

   localparam logic [1:0] SEL_RF  = 2'd0;
   localparam logic [1:0] SEL_MEM = 2'd1;
   localparam logic [1:0] SEL_WB  = 2'd2;

   slot_t             ex_q, ex_d;
   slot_t             mem_q, mem_d;
   slot_t             wb_q, wb_d;
   slot_t             id_slot_s;
   state_t            state_q, state_d;
   logic [2:0]        flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic              advance_s;
   logic              load_use_s;
   logic              pc_en_s;
   logic              fd_en_s;
   logic              fd_flush_s;
   logic              de_bubble_s;
   logic [1:0]        src_sel_s;
   logic [1:0]        dst_sel_s;
   logic [DATA_W-1:0] src_fwd_s;
   logic [DATA_W-1:0] dst_fwd_s;

   // A load in MEM has no data yet, so it never feeds the MEM path.
   function automatic logic mem_match(input slot_t s, input logic [REG_AW-1:0] addr);
      return s.valid & s.reg_write & ~s.mem_read & (s.rd == addr);
   endfunction

   // WB carries both ALU results and load data.
   function automatic logic wb_match(input slot_t s, input logic [REG_AW-1:0] addr);
      return s.valid & s.reg_write & (s.rd == addr);
   endfunction

   // Operand select with MEM taking priority over the older WB value.
   function automatic logic [1:0] fwd_sel(input slot_t m, input slot_t w,
                                          input logic used,
                                          input logic [REG_AW-1:0] addr);
      logic [1:0] sel;
      if (!used) begin
         sel = SEL_RF;
      end else if (mem_match(m, addr)) begin
         sel = SEL_MEM;
      end else if (wb_match(w, addr)) begin
         sel = SEL_WB;
      end else begin
         sel = SEL_RF;
      end
      return sel;
   endfunction

`ifdef HDU_LOAD_STALL_EN
   // True when a load sitting in slot s will write addr.
   function automatic logic load_match(input slot_t s, input logic [REG_AW-1:0] addr);
      return s.valid & s.reg_write & s.mem_read & (s.rd == addr);
   endfunction
`endif

   // Pack the decode-stage fields; a non-valid decode becomes an empty slot.
   always_comb begin
      id_slot_s = '0;
      if (hfu.id_valid) begin
         id_slot_s.valid     = 1'b1;
         id_slot_s.rs        = hfu.id_rs;
         id_slot_s.rd        = hfu.id_rd;
         id_slot_s.rs_used   = hfu.id_rs_used;
         id_slot_s.rd_used   = hfu.id_rd_used;
         id_slot_s.reg_write = hfu.id_reg_write;
         id_slot_s.mem_read  = hfu.id_mem_read;
      end else begin
         id_slot_s = '0;
      end
   end

   // Load-use detection against the loads still in EX or MEM.
`ifdef HDU_LOAD_STALL_EN
   always_comb begin
      load_use_s = hfu.id_valid &
                   ((hfu.id_rs_used & (load_match(ex_q, hfu.id_rs) | load_match(mem_q, hfu.id_rs))) |
                    (hfu.id_rd_used & (load_match(ex_q, hfu.id_rd) | load_match(mem_q, hfu.id_rd))));
   end
`else
   always_comb begin
      load_use_s = 1'b0;
   end
`endif

   // Forwarding selects for the instruction currently in EX.
   always_comb begin
      src_sel_s = fwd_sel(mem_q, wb_q, ex_q.valid & ex_q.rs_used, ex_q.rs);
      dst_sel_s = fwd_sel(mem_q, wb_q, ex_q.valid & ex_q.rd_used, ex_q.rd);
   end

   // Operand muxes driven by the selects.
   always_comb begin
      case (src_sel_s)
         SEL_MEM: src_fwd_s = hfu.mem_result;
         SEL_WB:  src_fwd_s = hfu.wb_result;
         default: src_fwd_s = hfu.ex_rs_data;
      endcase
      case (dst_sel_s)
         SEL_MEM: dst_fwd_s = hfu.mem_result;
         SEL_WB:  dst_fwd_s = hfu.wb_result;
         default: dst_fwd_s = hfu.ex_rd_data;
      endcase
   end

   // Control FSM next-state and pipeline controls.
   // Priority: reset > mem_hold > taken branch > load-use hazard.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      pc_en_s     = 1'b1;
      fd_en_s     = 1'b1;
      fd_flush_s  = 1'b0;
      de_bubble_s = 1'b0;
      advance_s   = 1'b0;
      if (!RESET) begin
         // Controls sit at their idle values while reset is asserted,
         // independent of what the pipeline presents.
         advance_s = 1'b0;
      end else if (hfu.mem_hold) begin
         // Full freeze; a branch presented now is ignored.
         pc_en_s = 1'b0;
         fd_en_s = 1'b0;
      end else begin
         advance_s = 1'b1;
         case (state_q)
            ST_RUN, ST_STALL: begin
               if (hfu.ex_branch_taken) begin
                  fd_flush_s  = 1'b1;
                  de_bubble_s = 1'b1;
                  flush_cnt_d = FLUSH_RELOAD;
                  if (FLUSH_RELOAD != 3'd0) begin
                     state_d = ST_FLUSH;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else if (load_use_s) begin
                  pc_en_s     = 1'b0;
                  fd_en_s     = 1'b0;
                  de_bubble_s = 1'b1;
                  state_d     = ST_STALL;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_FLUSH: begin
               fd_flush_s  = 1'b1;
               de_bubble_s = 1'b1;
               if (hfu.ex_branch_taken) begin
                  flush_cnt_d = FLUSH_RELOAD;
                  if (FLUSH_RELOAD != 3'd0) begin
                     state_d = ST_FLUSH;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else if (flush_cnt_q <= 3'd1) begin
                  flush_cnt_d = 3'd0;
                  state_d     = ST_RUN;
               end else begin
                  flush_cnt_d = flush_cnt_q - 3'd1;
                  state_d     = ST_FLUSH;
               end
            end
            default: begin
               flush_cnt_d = 3'd0;
               state_d     = ST_RUN;
            end
         endcase
      end
   end

   // Scoreboard shift: decode (or a bubble) enters EX, older slots age.
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (advance_s) begin
         if (de_bubble_s) begin
            ex_d = '0;
         end else begin
            ex_d = id_slot_s;
         end
         mem_d = ex_q;
         wb_d  = mem_q;
      end else begin
         ex_d  = ex_q;
         mem_d = mem_q;
         wb_d  = wb_q;
      end
   end

   // Saturating count of every advancing cycle that inserts a bubble.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (advance_s && de_bubble_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State registers; reset clears slots, FSM and counters.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         state_q     <= ST_RUN;
         flush_cnt_q <= 3'd0;
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hfu.pc_en       = pc_en_s;
   assign hfu.fd_en       = fd_en_s;
   assign hfu.fd_flush    = fd_flush_s;
   assign hfu.de_bubble   = de_bubble_s;
   assign hfu.fwd_src_sel = src_sel_s;
   assign hfu.fwd_dst_sel = dst_sel_s;
   assign hfu.src_fwd     = src_fwd_s;
   assign hfu.dst_fwd     = dst_fwd_s;
   assign hfu.state       = state_q;
   assign hfu.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed bench for hazard_forward_unit (FLUSH_DEPTH = 3).  Each task sets
// up one scenario, steps the clock and compares outputs against hand-worked
// values.  Inputs change 1 time unit after the rising edge; outputs are
// examined a further unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

   logic clk;
   logic RESET;
   int   n_checks;
   int   n_pass;

   hazard_forward_unit_if #(.REG_AW(3), .DATA_W(16), .CNT_W(16)) bus ();

   hazard_forward_unit #(
      .REG_AW(3), .DATA_W(16), .FLUSH_DEPTH(3), .CNT_W(16)
   ) dut (
      .clk   (clk),
      .RESET (RESET),
      .hfu   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [2:0] rs, input logic [2:0] rd,
                         input logic rsu, input logic rdu, input logic rw, input logic mr);
      bus.id_valid     = v;
      bus.id_rs        = rs;
      bus.id_rd        = rd;
      bus.id_rs_used   = rsu;
      bus.id_rd_used   = rdu;
      bus.id_reg_write = rw;
      bus.id_mem_read  = mr;
   endtask

   task automatic clear_id();
      set_id(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      bus.mem_hold = 1'b0;
      bus.ex_branch_taken = 1'b0;
      clear_id();
      step();
      step();
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      bus.mem_hold = 1'b1;
      bus.ex_branch_taken = 1'b1;
      set_id(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1);
      bus.ex_rs_data = 16'h1234;
      bus.ex_rd_data = 16'h5678;
      bus.mem_result = 16'hAAAA;
      bus.wb_result  = 16'hBBBB;
      #2;
      n_checks++; if (bus.pc_en !== 1'b1) $display("FAIL rst_pc_en: got %b expected 1", bus.pc_en); else n_pass++;
      n_checks++; if (bus.fd_en !== 1'b1) $display("FAIL rst_fd_en: got %b expected 1", bus.fd_en); else n_pass++;
      n_checks++; if (bus.fd_flush !== 1'b0) $display("FAIL rst_fd_flush: got %b expected 0", bus.fd_flush); else n_pass++;
      n_checks++; if (bus.de_bubble !== 1'b0) $display("FAIL rst_de_bubble: got %b expected 0", bus.de_bubble); else n_pass++;
      n_checks++; if (bus.fwd_src_sel !== 2'd0) $display("FAIL rst_src_sel: got %0d expected 0", bus.fwd_src_sel); else n_pass++;
      n_checks++; if (bus.fwd_dst_sel !== 2'd0) $display("FAIL rst_dst_sel: got %0d expected 0", bus.fwd_dst_sel); else n_pass++;
      n_checks++; if (bus.src_fwd !== 16'h1234) $display("FAIL rst_src_fwd: got %h expected 1234", bus.src_fwd); else n_pass++;
      n_checks++; if (bus.dst_fwd !== 16'h5678) $display("FAIL rst_dst_fwd: got %h expected 5678", bus.dst_fwd); else n_pass++;
      step();
      step();
      n_checks++; if (bus.state !== 2'd0) $display("FAIL rst_state: got %0d expected 0", bus.state); else n_pass++;
      n_checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL rst_stall_cnt: got %0d expected 0", bus.stall_cnt); else n_pass++;
      bus.mem_hold = 1'b0;
      bus.ex_branch_taken = 1'b0;
      clear_id();
      RESET = 1'b1;
   endtask

   task automatic test_forward_mem_wb();
      do_reset();
      bus.mem_result = 16'h0005;
      bus.wb_result  = 16'h00AA;
      bus.ex_rs_data = 16'h1111;
      bus.ex_rd_data = 16'h2222;
      set_id(1'b1, 3'd5, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD R1,R5
      step();
      set_id(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD R2,R1
      #1;
      n_checks++; if (bus.fwd_src_sel !== 2'd0) $display("FAIL first_src_sel: got %0d expected 0", bus.fwd_src_sel); else n_pass++;
      step();
      set_id(1'b1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD R4,R1
      #1;
      n_checks++; if (bus.fwd_src_sel !== 2'd1) $display("FAIL mem_src_sel: got %0d expected 1", bus.fwd_src_sel); else n_pass++;
      n_checks++; if (bus.src_fwd !== 16'h0005) $display("FAIL mem_src_fwd: got %h expected 0005", bus.src_fwd); else n_pass++;
      n_checks++; if (bus.fwd_dst_sel !== 2'd0) $display("FAIL mem_dst_sel: got %0d expected 0", bus.fwd_dst_sel); else n_pass++;
      n_checks++; if (bus.dst_fwd !== 16'h2222) $display("FAIL mem_dst_fwd: got %h expected 2222", bus.dst_fwd); else n_pass++;
      n_checks++; if (bus.pc_en !== 1'b1) $display("FAIL fwd_pc_en: got %b expected 1", bus.pc_en); else n_pass++;
      step();
      clear_id();
      #1;
      n_checks++; if (bus.fwd_src_sel !== 2'd2) $display("FAIL wb_src_sel: got %0d expected 2", bus.fwd_src_sel); else n_pass++;
      n_checks++; if (bus.src_fwd !== 16'h00AA) $display("FAIL wb_src_fwd: got %h expected 00aa", bus.src_fwd); else n_pass++;
      n_checks++; if (bus.fwd_dst_sel !== 2'd0) $display("FAIL wb_dst_sel: got %0d expected 0", bus.fwd_dst_sel); else n_pass++;
      step();
      n_checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL fwd_stall_cnt: got %0d expected 0", bus.stall_cnt); else n_pass++;
   endtask

   task automatic test_forward_priority();
      do_reset();
      bus.mem_result = 16'h0011;
      bus.wb_result  = 16'h0022;
      bus.ex_rs_data = 16'h7777;
      bus.ex_rd_data = 16'h3333;
      set_id(1'b1, 3'd0, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0);   // older write of R6
      step();
      set_id(1'b1, 3'd0, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0);   // younger write of R6
      step();
      set_id(1'b1, 3'd6, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0);   // reads R6 as src only
      step();
      clear_id();
      #1;
      n_checks++; if (bus.fwd_src_sel !== 2'd1) $display("FAIL prio_src_sel: got %0d expected 1", bus.fwd_src_sel); else n_pass++;
      n_checks++; if (bus.src_fwd !== 16'h0011) $display("FAIL prio_src_fwd: got %h expected 0011", bus.src_fwd); else n_pass++;
      n_checks++; if (bus.fwd_dst_sel !== 2'd0) $display("FAIL unused_dst_sel: got %0d expected 0", bus.fwd_dst_sel); else n_pass++;
      n_checks++; if (bus.dst_fwd !== 16'h3333) $display("FAIL unused_dst_fwd: got %h expected 3333", bus.dst_fwd); else n_pass++;
   endtask

   task automatic test_load_use();
      do_reset();
      bus.mem_result = 16'h0F0F;
      bus.wb_result  = 16'h3C3C;
      bus.ex_rs_data = 16'h1111;
      set_id(1'b1, 3'd7, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);   // LDD R3
      step();
      set_id(1'b1, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD R4,R3
      #1;
`ifdef HDU_LOAD_STALL_EN
      n_checks++; if (bus.pc_en !== 1'b0) $display("FAIL lu1_pc_en: got %b expected 0", bus.pc_en); else n_pass++;
      n_checks++; if (bus.fd_en !== 1'b0) $display("FAIL lu1_fd_en: got %b expected 0", bus.fd_en); else n_pass++;
      n_checks++; if (bus.de_bubble !== 1'b1) $display("FAIL lu1_bubble: got %b expected 1", bus.de_bubble); else n_pass++;
      n_checks++; if (bus.fd_flush !== 1'b0) $display("FAIL lu1_flush: got %b expected 0", bus.fd_flush); else n_pass++;
      step();
      n_checks++; if (bus.state !== 2'd1) $display("FAIL lu2_state: got %0d expected 1", bus.state); else n_pass++;
      n_checks++; if (bus.pc_en !== 1'b0) $display("FAIL lu2_pc_en: got %b expected 0", bus.pc_en); else n_pass++;
      n_checks++; if (bus.de_bubble !== 1'b1) $display("FAIL lu2_bubble: got %b expected 1", bus.de_bubble); else n_pass++;
      n_checks++; if (bus.stall_cnt !== 16'd1) $display("FAIL lu2_stall_cnt: got %0d expected 1", bus.stall_cnt); else n_pass++;
      step();
      n_checks++; if (bus.pc_en !== 1'b1) $display("FAIL lu3_pc_en: got %b expected 1", bus.pc_en); else n_pass++;
      n_checks++; if (bus.de_bubble !== 1'b0) $display("FAIL lu3_bubble: got %b expected 0", bus.de_bubble); else n_pass++;
      n_checks++; if (bus.stall_cnt !== 16'd2) $display("FAIL lu3_stall_cnt: got %0d expected 2", bus.stall_cnt); else n_pass++;
      step();
      clear_id();
      #1;
      n_checks++; if (bus.state !== 2'd0) $display("FAIL lu4_state: got %0d expected 0", bus.state); else n_pass++;
      n_checks++; if (bus.stall_cnt !== 16'd2) $display("FAIL lu4_stall_cnt: got %0d expected 2", bus.stall_cnt); else n_pass++;
`else
      n_checks++; if (bus.pc_en !== 1'b1) $display("FAIL nolu_pc_en: got %b expected 1", bus.pc_en); else n_pass++;
      n_checks++; if (bus.de_bubble !== 1'b0) $display("FAIL nolu_bubble: got %b expected 0", bus.de_bubble); else n_pass++;
      step();
      set_id(1'b1, 3'd3, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD R5,R3
      #1;
      n_checks++; if (bus.fwd_src_sel !== 2'd0) $display("FAIL load_mem_sel: got %0d expected 0", bus.fwd_src_sel); else n_pass++;
      n_checks++; if (bus.src_fwd !== 16'h1111) $display("FAIL load_mem_fwd: got %h expected 1111", bus.src_fwd); else n_pass++;
      n_checks++; if (bus.state !== 2'd0) $display("FAIL nolu_state: got %0d expected 0", bus.state); else n_pass++;
      step();
      clear_id();
      #1;
      n_checks++; if (bus.fwd_src_sel !== 2'd2) $display("FAIL load_wb_sel: got %0d expected 2", bus.fwd_src_sel); else n_pass++;
      n_checks++; if (bus.src_fwd !== 16'h3C3C) $display("FAIL load_wb_fwd: got %h expected 3c3c", bus.src_fwd); else n_pass++;
      n_checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL nolu_stall_cnt: got %0d expected 0", bus.stall_cnt); else n_pass++;
`endif
   endtask

`ifdef HDU_LOAD_STALL_EN
   task automatic test_branch_over_stall();
      do_reset();
      set_id(1'b1, 3'd7, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);   // LDD R3
      step();
      set_id(1'b1, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD R4,R3
      step();
      bus.ex_branch_taken = 1'b1;
      #1;
      n_checks++; if (bus.fd_flush !== 1'b1) $display("FAIL ovr_flush: got %b expected 1", bus.fd_flush); else n_pass++;
      n_checks++; if (bus.pc_en !== 1'b1) $display("FAIL ovr_pc_en: got %b expected 1", bus.pc_en); else n_pass++;
      n_checks++; if (bus.de_bubble !== 1'b1) $display("FAIL ovr_bubble: got %b expected 1", bus.de_bubble); else n_pass++;
      step();
      bus.ex_branch_taken = 1'b0;
      clear_id();
      #1;
      n_checks++; if (bus.state !== 2'd2) $display("FAIL ovr_state: got %0d expected 2", bus.state); else n_pass++;
   endtask
`endif

   task automatic test_branch_flush();
      do_reset();
      bus.ex_branch_taken = 1'b1;
      #1;
      n_checks++; if (bus.fd_flush !== 1'b1) $display("FAIL br0_flush: got %b expected 1", bus.fd_flush); else n_pass++;
      n_checks++; if (bus.de_bubble !== 1'b1) $display("FAIL br0_bubble: got %b expected 1", bus.de_bubble); else n_pass++;
      n_checks++; if (bus.pc_en !== 1'b1) $display("FAIL br0_pc_en: got %b expected 1", bus.pc_en); else n_pass++;
      n_checks++; if (bus.fd_en !== 1'b1) $display("FAIL br0_fd_en: got %b expected 1", bus.fd_en); else n_pass++;
      step();
      bus.ex_branch_taken = 1'b0;
      #1;
      n_checks++; if (bus.state !== 2'd2) $display("FAIL br1_state: got %0d expected 2", bus.state); else n_pass++;
      n_checks++; if (bus.fd_flush !== 1'b1) $display("FAIL br1_flush: got %b expected 1", bus.fd_flush); else n_pass++;
      n_checks++; if (bus.de_bubble !== 1'b1) $display("FAIL br1_bubble: got %b expected 1", bus.de_bubble); else n_pass++;
      step();
      n_checks++; if (bus.state !== 2'd2) $display("FAIL br2_state: got %0d expected 2", bus.state); else n_pass++;
      n_checks++; if (bus.fd_flush !== 1'b1) $display("FAIL br2_flush: got %b expected 1", bus.fd_flush); else n_pass++;
      step();
      n_checks++; if (bus.state !== 2'd0) $display("FAIL br3_state: got %0d expected 0", bus.state); else n_pass++;
      n_checks++; if (bus.fd_flush !== 1'b0) $display("FAIL br3_flush: got %b expected 0", bus.fd_flush); else n_pass++;
      n_checks++; if (bus.de_bubble !== 1'b0) $display("FAIL br3_bubble: got %b expected 0", bus.de_bubble); else n_pass++;
      n_checks++; if (bus.stall_cnt !== 16'd3) $display("FAIL br3_stall_cnt: got %0d expected 3", bus.stall_cnt); else n_pass++;
   endtask

   task automatic test_mem_hold();
      do_reset();
      bus.mem_result = 16'h0055;
      bus.wb_result  = 16'h0066;
      bus.ex_rs_data = 16'h1111;
      set_id(1'b1, 3'd0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);   // writes R1
      step();
      set_id(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);   // reads R1
      step();
      clear_id();
      bus.mem_hold = 1'b1;
      #1;
      n_checks++; if (bus.fwd_src_sel !== 2'd1) $display("FAIL hold_src_sel: got %0d expected 1", bus.fwd_src_sel); else n_pass++;
      n_checks++; if (bus.pc_en !== 1'b0) $display("FAIL hold_pc_en: got %b expected 0", bus.pc_en); else n_pass++;
      step();
      step();
      n_checks++; if (bus.fwd_src_sel !== 2'd1) $display("FAIL hold_sb_frozen: got %0d expected 1", bus.fwd_src_sel); else n_pass++;
      n_checks++; if (bus.src_fwd !== 16'h0055) $display("FAIL hold_src_fwd: got %h expected 0055", bus.src_fwd); else n_pass++;
      bus.mem_hold = 1'b0;
      step();
      bus.ex_branch_taken = 1'b1;
      step();
      bus.ex_branch_taken = 1'b1;   // presented during the hold, must be ignored
      bus.mem_hold = 1'b1;
      #1;
      n_checks++; if (bus.pc_en !== 1'b0) $display("FAIL hflush_pc_en: got %b expected 0", bus.pc_en); else n_pass++;
      n_checks++; if (bus.fd_flush !== 1'b0) $display("FAIL hflush_flush: got %b expected 0", bus.fd_flush); else n_pass++;
      n_checks++; if (bus.de_bubble !== 1'b0) $display("FAIL hflush_bubble: got %b expected 0", bus.de_bubble); else n_pass++;
      for (int i = 0; i < 4; i++) step();
      n_checks++; if (bus.state !== 2'd2) $display("FAIL hflush_state: got %0d expected 2", bus.state); else n_pass++;
      n_checks++; if (bus.stall_cnt !== 16'd1) $display("FAIL hflush_stall_cnt: got %0d expected 1", bus.stall_cnt); else n_pass++;
      bus.ex_branch_taken = 1'b0;
      bus.mem_hold = 1'b0;
      #1;
      n_checks++; if (bus.fd_flush !== 1'b1) $display("FAIL resume_flush: got %b expected 1", bus.fd_flush); else n_pass++;
      n_checks++; if (bus.pc_en !== 1'b1) $display("FAIL resume_pc_en: got %b expected 1", bus.pc_en); else n_pass++;
      step();
      n_checks++; if (bus.state !== 2'd2) $display("FAIL resume1_state: got %0d expected 2", bus.state); else n_pass++;
      n_checks++; if (bus.stall_cnt !== 16'd2) $display("FAIL resume1_stall_cnt: got %0d expected 2", bus.stall_cnt); else n_pass++;
      step();
      n_checks++; if (bus.state !== 2'd0) $display("FAIL resume2_state: got %0d expected 0", bus.state); else n_pass++;
      n_checks++; if (bus.stall_cnt !== 16'd3) $display("FAIL resume2_stall_cnt: got %0d expected 3", bus.stall_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      bus.ex_branch_taken = 1'b1;
      step();
      bus.ex_branch_taken = 1'b0;
      step();
      step();
      bus.ex_branch_taken = 1'b1;
      step();
      bus.ex_branch_taken = 1'b0;
      step();
      n_checks++; if (bus.stall_cnt !== 16'd5) $display("FAIL mid_stall_cnt: got %0d expected 5", bus.stall_cnt); else n_pass++;
      n_checks++; if (bus.state !== 2'd2) $display("FAIL mid_state: got %0d expected 2", bus.state); else n_pass++;
      n_checks++; if (bus.fd_flush !== 1'b1) $display("FAIL mid_flush: got %b expected 1", bus.fd_flush); else n_pass++;
      #1;
      RESET = 1'b0;
      #1;
      n_checks++; if (bus.pc_en !== 1'b1) $display("FAIL arst_pc_en: got %b expected 1", bus.pc_en); else n_pass++;
      n_checks++; if (bus.fd_flush !== 1'b0) $display("FAIL arst_flush: got %b expected 0", bus.fd_flush); else n_pass++;
      n_checks++; if (bus.de_bubble !== 1'b0) $display("FAIL arst_bubble: got %b expected 0", bus.de_bubble); else n_pass++;
      n_checks++; if (bus.state !== 2'd0) $display("FAIL arst_state: got %0d expected 0", bus.state); else n_pass++;
      n_checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL arst_stall_cnt: got %0d expected 0", bus.stall_cnt); else n_pass++;
      step();
      RESET = 1'b1;
      step();
      n_checks++; if (bus.state !== 2'd0) $display("FAIL post_state: got %0d expected 0", bus.state); else n_pass++;
      n_checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL post_stall_cnt: got %0d expected 0", bus.stall_cnt); else n_pass++;
      n_checks++; if (bus.fd_flush !== 1'b0) $display("FAIL post_flush: got %b expected 0", bus.fd_flush); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      RESET    = 1'b0;
      bus.mem_hold        = 1'b0;
      bus.ex_branch_taken = 1'b0;
      bus.ex_rs_data      = 16'h0000;
      bus.ex_rd_data      = 16'h0000;
      bus.mem_result      = 16'h0000;
      bus.wb_result       = 16'h0000;
      clear_id();

      test_reset();
      test_forward_mem_wb();
      test_forward_priority();
      test_load_use();
`ifdef HDU_LOAD_STALL_EN
      test_branch_over_stall();
`endif
      test_branch_flush();
      test_mem_hold();
      test_reset_mid_flush();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard-detection and forwarding controller for the five-stage pipeline, replacing the standalone forwarding unit and its two operand muxes. It keeps its own scoreboard of the instructions in EX, MEM and WB, forwards operands into the ALU, and generates PC/IF-ID enables, IF-ID flush and ID-EX bubble. New relative to the previous forwarding logic:
- load-use stalls
- multi-cycle branch flush
- global memory-hold freeze
- a stall performance counter

## Interface
- REG_AW, 3, register address width
- DATA_W, 16, operand width
- FLUSH_DEPTH, 2, cycles of IF-ID flush after a taken branch/jump (1..7)
- CNT_W, 16, width of stall counter
- clk  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- mem_hold  in  1  memory stage busy; freezes whole pipeline
- id_valid  in  1  decode slot holds a real instruction
- id_rs, id_rd  in  REG_AW each  decode source/destination addresses
- id_rs_used, id_rd_used  in  1 each  operand actually read
- id_reg_write, id_mem_read  in  1 each  decode writes a register / is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- ex_rs_data, ex_rd_data  in  DATA_W each  operands from ID-EX register (rs after immediate mux)
- mem_result  in  DATA_W  ALU result in EX-MEM register
- wb_result  in  DATA_W  write-back data
- pc_en, fd_en  out  1 each  PC and IF-ID register enables
- fd_flush  out  1  clear IF-ID to NOP
- de_bubble  out  1  load NOP into ID-EX
- fwd_src_sel, fwd_dst_sel  out  2 each  0 = register file, 1 = MEM, 2 = WB
- src_fwd, dst_fwd  out  DATA_W each  forwarded ALU operands
- state  out  2  0 RUN, 1 STALL, 2 FLUSH
- stall_cnt  out  CNT_W  saturating count of stall + flush cycles

## Operation
- Scoreboard holds three slots: EX, MEM, WB. Each slot is {valid, rs, rd, rs_used, rd_used, reg_write, mem_read}.
- Advance on every clk edge unless mem_hold=1:
  - EX takes the decode fields, or an all-invalid bubble when de_bubble=1.
  - MEM takes EX; WB takes MEM.
- Forwarding, per EX operand (rs/rs_used, rd/rd_used):
  - MEM match (valid & reg_write & !mem_read & equal address) → sel 1.
  - Otherwise WB match (valid & reg_write) → sel 2.
  - Otherwise 0.
  - MEM has priority over WB. Unused operand → sel 0.
- Load-use hazard: id_valid, and a used decode operand matches the EX or MEM slot with valid & reg_write & mem_read. Load data exists only at WB, so a load immediately followed by its consumer costs 2 stall cycles.
- FSM:
  - RUN: branch → FLUSH (counter = FLUSH_DEPTH-1); else hazard → STALL; else RUN.
  - STALL: stays while the hazard persists; branch overrides → FLUSH.
  - FLUSH: counter decrements each advancing cycle; exits to RUN at 0.
  - FLUSH_DEPTH=1 → stays RUN.
- Combinational controls:
  - branch: fd_flush=1, de_bubble=1, pc_en=fd_en=1.
  - hazard (no branch): pc_en=fd_en=0, de_bubble=1.
  - FLUSH state: fd_flush=1, de_bubble=1.
  - mem_hold=1: pc_en=fd_en=0, fd_flush=de_bubble=0. Forwarding still valid.
- Priority: mem_hold > branch > load-use hazard.
- ex_branch_taken is ignored while mem_hold=1.
- stall_cnt increments on each non-held cycle with de_bubble=1, saturating at all-ones.

## Timing
- Forwarding selects and data are combinational from scoreboard and inputs, with no added latency.
- Scoreboard, state, flush counter and stall_cnt are registered.
- Reset (RESET=0, async): all slots invalid, state RUN, counter 0, stall_cnt 0.
  - Outputs during reset: pc_en=fd_en=1, fd_flush=de_bubble=0, selects 0, src_fwd=ex_rs_data, dst_fwd=ex_rd_data.
- Reset asserted mid-stall or mid-flush aborts it immediately.
- On the first edge after release, the decode slot enters EX normally.
- Hazard check uses current slots, so STALL exits in the same cycle the load reaches WB.

## Configuration
- HDU_LOAD_STALL_EN defined: load-use detection and STALL state as above.
- Undefined:
  - no load-use detection; STALL is never entered.
  - The compiler/assembler inserts two NOPs after a load.
  - A load in MEM is still excluded from MEM forwarding.

## Test plan
- ADD R1 then ADD R2,R1 back-to-back:
  - fwd_src_sel=1, src_fwd=mem_result (0x0005).
  - One cycle later a consumer of R1 gets sel=2, src_fwd=wb_result.
- Same register written in MEM (0x0011) and WB (0x0022) → MEM value 0x0011 wins.
- LDD R3 then ADD R4,R3 with HDU_LOAD_STALL_EN:
  - 2 cycles of pc_en=0, de_bubble=1, state=STALL.
  - Then sel=2; stall_cnt=2.
- ex_branch_taken pulse with FLUSH_DEPTH=3: fd_flush=1 for exactly 3 advancing cycles, state FLUSH for 2; branch during STALL overrides it.
- mem_hold=1 for 4 cycles during FLUSH: counter, scoreboard and stall_cnt frozen, pc_en=0; flush resumes after release.
- RESET low mid-FLUSH with stall_cnt=5:
  - All outputs at reset values immediately (async).
  - stall_cnt=0, state RUN after release.
